// File: rtl/spi_bus_arbiter.sv
// Two-requester arbiter in front of one shared SPI byte engine: round-robin ownership,
// burst hold of chip select, an idle gap between owners and a completion timeout.
module spi_bus_arbiter #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        lock,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic              eng_processing,
    input  logic              eng_data_valid,
    input  logic [DATA_W-1:0] eng_dout,
    output logic              eng_send_request,
    output logic [DATA_W-1:0] eng_din,
    output logic [1:0]        gnt,
    output logic [1:0]        cs_n,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, GAP} ArbState;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT);

    ArbState r_state;
    ArbState w_nextState;

    logic              r_owner, w_owner;
    logic              r_last, w_last;
    logic              r_dvPrev;
    logic [7:0]        r_toCnt, w_toCnt;
    logic [GAP_W-1:0]  r_gapCnt, w_gapCnt;
    logic [1:0]        r_gnt, w_gnt;
    logic [1:0]        r_csN, w_csN;
    logic [1:0]        r_rspValid, w_rspValid;
    logic              r_send, w_send;
    logic              r_err, w_err;
    logic [DATA_W-1:0] r_din, w_din;
    logic [DATA_W-1:0] r_rspData, w_rspData;

    logic       w_pick;
    logic       w_complete;
    logic       w_abort;
    logic       w_burst;
    logic       w_release;
    logic [8:0] w_toInc;

    // The engine busy flag carries no control meaning here; progress is judged only by data_valid edges.
    logic w_unusedEngBusy;
    assign w_unusedEngBusy = eng_processing;

    assign w_pick     = (req == 2'b11) ? ~r_last : req[1];
    assign w_toInc    = {1'b0, r_toCnt} + 9'd1;
    assign w_complete = (r_state == BUSY) && eng_data_valid && !r_dvPrev;
    assign w_abort    = (r_state == BUSY) && !w_complete && (w_toInc >= TIMEOUT_LIMIT);
    assign w_burst    = w_complete && lock[r_owner] && req[r_owner];
    assign w_release  = (w_complete && !w_burst) || w_abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (req != 2'b00) begin
                    w_nextState = LAUNCH;
                end
            end
            LAUNCH: begin
                w_nextState = BUSY;
            end
            BUSY: begin
                if (w_burst) begin
                    w_nextState = LAUNCH;
                end else if (w_release) begin
                    w_nextState = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (r_gapCnt == GAP_LAST) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        w_gnt      = r_gnt;
        w_csN      = r_csN;
        w_send     = 1'b0;
        w_din      = r_din;
        w_rspValid = 2'b00;
        w_rspData  = r_rspData;
        w_err      = 1'b0;
        w_owner    = r_owner;
        w_last     = r_last;
        w_toCnt    = r_toCnt;
        w_gapCnt   = r_gapCnt;
        case (r_state)
            IDLE: begin
                if (req != 2'b00) begin
                    w_owner = w_pick;
                    w_last  = w_pick;
                    w_gnt   = w_pick ? 2'b10 : 2'b01;
                    w_csN   = w_pick ? 2'b01 : 2'b10;
                    w_send  = 1'b1;
                    w_din   = w_pick ? din1 : din0;
                end
            end
            LAUNCH: begin
                w_toCnt = '0;
            end
            BUSY: begin
                w_toCnt = w_toInc[7:0];
                if (w_complete) begin
                    w_rspValid[r_owner] = 1'b1;
                    w_rspData           = eng_dout;
                end
                // A burst continuation counts as a fresh grant for round-robin purposes.
                if (w_burst) begin
                    w_send = 1'b1;
                    w_din  = r_owner ? din1 : din0;
                    w_last = r_owner;
                end
                if (w_release) begin
                    w_gnt    = 2'b00;
                    w_csN    = 2'b11;
                    w_gapCnt = '0;
                end
                w_err = w_abort;
            end
            GAP: begin
                w_gapCnt = r_gapCnt + GAP_W'(1);
            end
            default: begin
                w_gnt = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt      <= 2'b00;
            r_csN      <= 2'b11;
            r_send     <= 1'b0;
            r_din      <= '0;
            r_rspValid <= 2'b00;
            r_rspData  <= '0;
            r_err      <= 1'b0;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_toCnt    <= '0;
            r_gapCnt   <= '0;
            r_dvPrev   <= 1'b0;
        end else begin
            r_gnt      <= w_gnt;
            r_csN      <= w_csN;
            r_send     <= w_send;
            r_din      <= w_din;
            r_rspValid <= w_rspValid;
            r_rspData  <= w_rspData;
            r_err      <= w_err;
            r_owner    <= w_owner;
            r_last     <= w_last;
            r_toCnt    <= w_toCnt;
            r_gapCnt   <= w_gapCnt;
            r_dvPrev   <= eng_data_valid;
        end
    end

    assign gnt              = r_gnt;
    assign cs_n             = r_csN;
    assign eng_send_request = r_send;
    assign eng_din          = r_din;
    assign rsp_valid        = r_rspValid;
    assign rsp_data         = r_rspData;
    assign err              = r_err;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: a transaction-level model of ownership, byte ages and gaps is
// compared against the DUT every cycle, alongside directed scenarios with literal expectations.
module tb_spi_bus_arbiter;
    localparam int DATA_W     = 8;
    localparam int GAP_CYCLES = 2;
    localparam int TIMEOUT    = 255;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        reqS = 2'b00;
    logic [1:0]        lockS = 2'b00;
    logic [DATA_W-1:0] din0S = '0;
    logic [DATA_W-1:0] din1S = '0;
    logic [DATA_W-1:0] doutS = '0;
    logic              dvS = 1'b0;
    logic              procS = 1'b0;

    logic              engSend;
    logic [DATA_W-1:0] engDin;
    logic [1:0]        gnt;
    logic [1:0]        csN;
    logic [1:0]        rspValid;
    logic [DATA_W-1:0] rspData;
    logic              err;

    spi_bus_arbiter #(
        .DATA_W(DATA_W),
        .GAP_CYCLES(GAP_CYCLES),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(reqS),
        .lock(lockS),
        .din0(din0S),
        .din1(din1S),
        .eng_processing(procS),
        .eng_data_valid(dvS),
        .eng_dout(doutS),
        .eng_send_request(engSend),
        .eng_din(engDin),
        .gnt(gnt),
        .cs_n(csN),
        .rsp_valid(rspValid),
        .rsp_data(rspData),
        .err(err)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nMis = 0;
    bit checkEn = 1'b0;

    // Engine emulator settings; random mode re-draws them on every start pulse.
    bit                engRandom = 1'b0;
    bit                engNoResp = 1'b0;
    bit                engFixed = 1'b0;
    logic [DATA_W-1:0] engFixedVal = '0;
    int                engLatency = 3;
    int                engHoldLen = 1;
    int                engWait = 0;
    int                engHold = 0;

    // Model: whether the bus is owned, by whom, how many cycles the current byte has waited.
    bit                mBusy = 1'b0;
    logic              mOwn = 1'b0;
    logic              mLast = 1'b1;
    int                mAge = 0;
    int                mGapLeft = 0;
    logic              mPrevDv = 1'b0;
    logic [1:0]        expGnt = 2'b00;
    logic [1:0]        expCsn = 2'b11;
    logic [1:0]        expRspValid = 2'b00;
    logic              expSend = 1'b0;
    logic              expErr = 1'b0;
    logic [DATA_W-1:0] expDin = '0;
    logic [DATA_W-1:0] expRspData = '0;

    task automatic modelGrant();
        mBusy   = 1'b1;
        mLast   = mOwn;
        mAge    = 0;
        expSend = 1'b1;
        expDin  = mOwn ? din1S : din0S;
        expGnt  = mOwn ? 2'b10 : 2'b01;
        expCsn  = ~expGnt;
    endtask

    task automatic modelRelease();
        mBusy    = 1'b0;
        mGapLeft = GAP_CYCLES;
        expGnt   = 2'b00;
        expCsn   = 2'b11;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mBusy = 1'b0; mOwn = 1'b0; mLast = 1'b1; mAge = 0; mGapLeft = 0; mPrevDv = 1'b0;
            expGnt = 2'b00; expCsn = 2'b11; expRspValid = 2'b00; expSend = 1'b0;
            expErr = 1'b0; expDin = '0; expRspData = '0;
        end else begin
            expSend = 1'b0;
            expRspValid = 2'b00;
            expErr = 1'b0;
            if (!mBusy) begin
                if (mGapLeft > 0) begin
                    mGapLeft--;
                end else if (reqS != 2'b00) begin
                    mOwn = (reqS == 2'b11) ? ~mLast : reqS[1];
                    modelGrant();
                end
            end else if (mAge == 0) begin
                mAge = 1;
            end else if (dvS && !mPrevDv) begin
                expRspValid = mOwn ? 2'b10 : 2'b01;
                expRspData  = doutS;
                if (lockS[mOwn] && reqS[mOwn]) modelGrant();
                else modelRelease();
            end else if (mAge >= TIMEOUT) begin
                expErr = 1'b1;
                modelRelease();
            end else begin
                mAge++;
            end
            mPrevDv = dvS;
        end
    end

    task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        compareField("gnt", {30'd0, gnt}, {30'd0, expGnt});
        compareField("cs_n", {30'd0, csN}, {30'd0, expCsn});
        compareField("eng_send_request", {31'd0, engSend}, {31'd0, expSend});
        compareField("eng_din", {24'd0, engDin}, {24'd0, expDin});
        compareField("rsp_valid", {30'd0, rspValid}, {30'd0, expRspValid});
        compareField("rsp_data", {24'd0, rspData}, {24'd0, expRspData});
        compareField("err", {31'd0, err}, {31'd0, expErr});
    endtask

    always @(negedge clk) begin
        if (checkEn) checkOutput();
    end

    task automatic engineStep();
        if (engHold > 0) begin
            engHold--;
            if (engHold == 0) dvS = 1'b0;
        end
        if (!engFixed) doutS = DATA_W'($urandom);
        if (engWait > 0) begin
            engWait--;
            if (engWait == 0) begin
                dvS = 1'b1;
                procS = 1'b0;
                engHold = engHoldLen;
                if (engFixed) doutS = engFixedVal;
            end
        end
        if (engSend) begin
            if (engRandom) begin
                engLatency = $urandom_range(1, 10);
                engHoldLen = $urandom_range(1, 5);
                engNoResp  = ($urandom_range(0, 39) == 0);
            end
            procS = 1'b1;
            engWait = engNoResp ? 0 : engLatency;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] l,
                                 input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
        @(negedge clk);
        engineStep();
        reqS  = r;
        lockS = l;
        din0S = d0;
        din1S = d1;
    endtask

    task automatic waitSend(input logic [1:0] r, input logic [1:0] l,
                            input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            applyStimulus(r, l, d0, d1);
            ok = engSend;
        end
        compareField(name, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int sends, rsps, cnt, idleRun, nGrants;
        bit found, sawOther;
        logic [1:0] r, l, prevGnt;
        logic [1:0] grants [4];

        applyStimulus(2'b00, 2'b00, '0, '0);
        compareField("rst_gnt", {30'd0, gnt}, 32'h0);
        compareField("rst_csn", {30'd0, csN}, 32'h3);
        compareField("rst_send", {31'd0, engSend}, 32'h0);
        compareField("rst_din", {24'd0, engDin}, 32'h0);
        compareField("rst_rspv", {30'd0, rspValid}, 32'h0);
        compareField("rst_err", {31'd0, err}, 32'h0);
        checkEn = 1'b1;
        applyStimulus(2'b00, 2'b00, '0, '0);
        reset = 1'b0;

        $display("[TB] single byte from requester 0");
        engLatency = 8; engHoldLen = 1; engFixed = 1'b1; engFixedVal = 8'hA5;
        waitSend(2'b01, 2'b00, 8'h03, 8'h00, "t1_send");
        compareField("t1_gnt", {30'd0, gnt}, 32'h1);
        compareField("t1_csn", {30'd0, csN}, 32'h2);
        compareField("t1_din", {24'd0, engDin}, 32'h03);
        sends = 0; found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            applyStimulus(2'b00, 2'b00, 8'h5A, 8'h00);
            if (engSend) sends++;
            found = (rspValid != 2'b00);
        end
        compareField("t1_rsp_seen", {31'd0, found}, 32'h1);
        compareField("t1_rspv", {30'd0, rspValid}, 32'h1);
        compareField("t1_rsp_data", {24'd0, rspData}, 32'hA5);
        compareField("t1_extra_send", sends, 32'h0);
        compareField("t1_din_hold", {24'd0, engDin}, 32'h03);
        applyStimulus(2'b00, 2'b00, 8'h00, 8'h00);
        compareField("t1_gap_csn", {30'd0, csN}, 32'h3);
        compareField("t1_gap_gnt", {30'd0, gnt}, 32'h0);

        $display("[TB] data_valid level held for 5 cycles");
        engLatency = 2; engHoldLen = 5; engFixed = 1'b0;
        waitSend(2'b01, 2'b00, 8'h11, 8'h22, "t2_send");
        rsps = 0;
        for (int i = 0; i < 25; i++) begin
            applyStimulus(2'b00, 2'b00, 8'h00, 8'h00);
            if (rspValid[0]) rsps++;
        end
        compareField("t2_single_rsp", rsps, 32'd1);

        $display("[TB] four-byte locked burst with a waiting second requester");
        engLatency = 3; engHoldLen = 1;
        waitSend(2'b01, 2'b01, 8'h40, 8'h80, "t3_send");
        compareField("t3_gnt0", {30'd0, gnt}, 32'h1);
        sends = 1; rsps = 0; sawOther = 1'b0;
        for (int i = 0; i < 200; i++) begin
            r = (rsps >= 3) ? 2'b10 : 2'b11;
            l = (rsps >= 3) ? 2'b00 : 2'b01;
            applyStimulus(r, l, DATA_W'($urandom), DATA_W'($urandom));
            if (engSend) sends++;
            if (rspValid[0]) rsps++;
            if (gnt[1]) sawOther = 1'b1;
            if (csN[0]) break;
        end
        compareField("t3_sends", sends, 32'd4);
        compareField("t3_rsps", rsps, 32'd4);
        compareField("t3_no_preempt", {31'd0, sawOther}, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(2'b10, 2'b00, 8'h00, 8'h77);
            found = (gnt != 2'b00);
        end
        compareField("t3_gnt1_after", {30'd0, gnt}, 32'h2);
        for (int i = 0; i < 20; i++) applyStimulus(2'b00, 2'b00, 8'h00, 8'h00);

        $display("[TB] engine never completes");
        engNoResp = 1'b1;
        waitSend(2'b10, 2'b00, 8'h00, 8'h99, "t4_send");
        cnt = 0; found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            applyStimulus(2'b00, 2'b00, 8'h00, 8'h00);
            cnt++;
            found = err;
        end
        compareField("t4_err_seen", {31'd0, found}, 32'h1);
        compareField("t4_err_delay", cnt, 32'd256);
        compareField("t4_csn", {30'd0, csN}, 32'h3);
        compareField("t4_rspv", {30'd0, rspValid}, 32'h0);

        $display("[TB] reset while requester 1 is mid-byte");
        waitSend(2'b10, 2'b00, 8'h00, 8'h3C, "t5_send");
        for (int i = 0; i < 3; i++) applyStimulus(2'b10, 2'b00, 8'h00, 8'h3C);
        #2;
        reset = 1'b1;
        engWait = 0; engHold = 0; dvS = 1'b0; procS = 1'b0;
        #1;
        compareField("t5_async_gnt", {30'd0, gnt}, 32'h0);
        compareField("t5_async_csn", {30'd0, csN}, 32'h3);
        compareField("t5_async_din", {24'd0, engDin}, 32'h0);
        applyStimulus(2'b11, 2'b00, 8'h00, 8'h00);
        reset = 1'b0;
        engNoResp = 1'b0; engLatency = 3; engHoldLen = 1;
        for (int k = 0; k < 4; k++) grants[k] = 2'b00;
        nGrants = 0; idleRun = 0; prevGnt = 2'b00;
        for (int i = 0; i < 200 && nGrants < 4; i++) begin
            applyStimulus(2'b11, 2'b00, DATA_W'($urandom), DATA_W'($urandom));
            compareField("t5_cs_exclusive", {31'd0, (csN != 2'b00)}, 32'h1);
            if (gnt == 2'b00) begin
                idleRun++;
            end else if (prevGnt == 2'b00) begin
                if (nGrants > 0) compareField("t5_idle_gap", {31'd0, (idleRun >= 2)}, 32'h1);
                grants[nGrants] = gnt;
                nGrants++;
                idleRun = 0;
            end
            prevGnt = gnt;
        end
        compareField("t5_grant_count", nGrants, 32'd4);
        compareField("t5_grant0", {30'd0, grants[0]}, 32'h1);
        compareField("t5_grant1", {30'd0, grants[1]}, 32'h2);
        compareField("t5_grant2", {30'd0, grants[2]}, 32'h1);
        compareField("t5_grant3", {30'd0, grants[3]}, 32'h2);
        for (int i = 0; i < 20; i++) applyStimulus(2'b00, 2'b00, 8'h00, 8'h00);

        $display("[TB] randomized traffic");
        engRandom = 1'b1;
        r = 2'b00; l = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) r = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) l = 2'($urandom_range(0, 3));
            applyStimulus(r, l, DATA_W'($urandom), DATA_W'($urandom));
        end
        for (int i = 0; i < 300; i++) applyStimulus(2'b00, 2'b00, 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, byte width of the shared SPI engine data path.
REQ-002 Parameter GAP_CYCLES, default 2, idle cycles inserted between bus owners (0 allowed).
REQ-003 Parameter TIMEOUT, default 255, max cycles waiting for engine completion before abort (8-bit counter).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  2  per-requester transfer request, level; index 0 = EEPROM loader, 1 = HC595 output.
REQ-007 lock  input  2  per-requester burst hold; keep bus and CS after a byte while req stays high.
REQ-008 din0, din1  input  DATA_W each  byte to send for requester 0 / 1.
REQ-009 eng_processing  input  1  shared engine busy.
REQ-010 eng_data_valid  input  1  shared engine byte complete (level).
REQ-011 eng_dout  input  DATA_W  shared engine received byte.
REQ-012 eng_send_request  output  1  one-cycle start pulse to engine.
REQ-013 eng_din  output  DATA_W  byte presented to engine.
REQ-014 gnt  output  2  one-hot grant, zero when no owner.
REQ-015 cs_n  output  2  per-requester chip select, active low.
REQ-016 rsp_valid  output  2  one-cycle pulse to owner: byte done.
REQ-017 rsp_data  output  DATA_W  received byte, valid with rsp_valid.
REQ-018 err  output  1  one-cycle pulse on timeout abort.

Function
REQ-019 FSM states SHALL be IDLE, LAUNCH, BUSY, GAP; all outputs registered.
REQ-020 IDLE: with any req high, SHALL pick owner round-robin (prefer index not granted last; lone requester wins), then next cycle: state LAUNCH, gnt[owner]=1, cs_n[owner]=0.
REQ-021 Owner's din SHALL be latched into eng_din on the IDLE->LAUNCH and BUSY->LAUNCH transitions and held stable until the next latch.
REQ-022 LAUNCH: eng_send_request SHALL be 1 for exactly that one cycle; next state BUSY; timeout counter cleared.
REQ-023 BUSY: completion = eng_data_valid high while previous-cycle eng_data_valid low (rising edge only); a level held high SHALL NOT complete a second byte.
REQ-024 On completion: rsp_data<=eng_dout, rsp_valid[owner]=1 for one cycle.
REQ-025 On completion with lock[owner]&req[owner]: next state LAUNCH, gnt and cs_n unchanged (burst, no CS release).
REQ-026 On completion otherwise: next state GAP (IDLE if GAP_CYCLES=0), gnt<=0, cs_n<=2'b11.
REQ-027 GAP: stay exactly GAP_CYCLES cycles with gnt=0, cs_n=11, then IDLE.
REQ-028 Timeout counter SHALL increment each BUSY cycle; reaching TIMEOUT without completion: err pulse, no rsp_valid, release as REQ-026.
REQ-029 Last-granted pointer SHALL update on every grant, including burst continuation.
REQ-030 req/lock deassertion during LAUNCH/BUSY SHALL NOT abort the byte in flight.
REQ-031 Requests from a non-owner SHALL wait; never preempt the owner.
REQ-032 Simultaneous completion and timeout in the same cycle: completion wins, no err.
REQ-033 Engine eng_processing SHALL be ignored except for transition out of BUSY is never gated on it; it is informational only.

Reset
REQ-034 reset high SHALL immediately force: state IDLE, gnt=0, cs_n=11, eng_send_request=0, eng_din=0, rsp_valid=0, rsp_data=0, err=0, counters 0, last-granted pointer=1 (so requester 0 wins first).
REQ-035 reset asserted mid-transfer SHALL drop CS at once; the byte is lost, no rsp_valid after release.

Verification
REQ-036 Single req[0], din0=0x03, engine returns 0xA5 after 8 cycles -> cs_n=10, one send pulse, rsp_valid[0] pulse with rsp_data=0xA5, then 2 gap cycles, cs_n=11.
REQ-037 req=11 held, no lock -> grants alternate 0,1,0,1; cs_n never both low; >=2 idle cycles between owners.
REQ-038 req[0]&lock[0] for 4 bytes -> cs_n[0] stays low across all 4, exactly 4 send pulses and 4 rsp_valid[0]; req[1] served only after.
REQ-039 eng_data_valid never rises, TIMEOUT=255 -> err pulse 256 cycles after LAUNCH, no rsp_valid, bus released.
REQ-040 reset pulsed during BUSY of requester 1 -> cs_n=11, gnt=0 asynchronously; after release req=11 grants requester 0 first.
REQ-041 eng_data_valid held high 5 cycles -> single rsp_valid pulse, single completion.
